// File: rtl/trng_pkg.sv
// Shared types, constants and helpers for the TRNG burst controller.
package trng_pkg;

  // Burst flow-control states.
  typedef enum logic [0:0] {
    ST_SEND  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Output formatting modes.
  localparam logic MODE_RAW  = 1'b0;
  localparam logic MODE_PACK = 1'b1;

  // Width of the optional drop counter.
  localparam int DROP_W = 16;

  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Saturating add of a small increment onto a DROP_W-bit count.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                               input logic [3:0]        b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W-3){1'b0}}, b};
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/trng_bit_packer.sv
// Collects single bits MSB first into a byte. BYTE_DONE flags that the
// packer already holds seven bits, so a SHIFT this cycle completes the byte
// and BYTE_OUT (old bits plus BIT_IN) is the finished byte.
module trng_bit_packer
  import trng_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CLR,
  input  logic       SHIFT,
  input  logic       BIT_IN,
  output logic [7:0] BYTE_OUT,
  output logic       BYTE_DONE
);

  logic [6:0] shift_r;
  logic [2:0] cnt_r;

  assign BYTE_OUT  = {shift_r, BIT_IN};
  assign BYTE_DONE = (cnt_r == 3'd7);

  // Shift register and bit count; the completing shift empties the packer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_r <= 7'd0;
      cnt_r   <= 3'd0;
    end else if (CLR) begin
      shift_r <= 7'd0;
      cnt_r   <= 3'd0;
    end else if (SHIFT) begin
      if (cnt_r == 3'd7) begin
        shift_r <= 7'd0;
        cnt_r   <= 3'd0;
      end else begin
        shift_r <= {shift_r[5:0], BIT_IN};
        cnt_r   <= cnt_r + 3'd1;
      end
    end
  end

endmodule

// File: rtl/trng_burst_ctrl.sv
// Multi-channel sample collector and burst flow controller.
// Per-channel hold registers feed a round-robin arbiter; granted samples go
// to the output register directly (raw) or through the bit packer. After
// BURST_LEN handshakes the block pauses until the UART FIFO is empty.
// Optional build macro TRNG_DROP_CNT_EN adds the DROP_CNT overwrite counter.
module trng_burst_ctrl
  import trng_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int BURST_LEN = 4000,
  parameter int CNT_W     = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MODE,
  input  logic [NCH*8-1:0] SMP_DATA,
  input  logic [NCH-1:0]   SMP_EN,
  output logic [7:0]       DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  input  logic             UART_EMPTY,
  output logic             BURST_ACT
`ifdef TRNG_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] DROP_CNT
`endif
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] burst_cnt_r;

  logic [7:0]       hold_data_r [NCH];
  logic [NCH-1:0]   hold_full_r;
  logic [IDX_W-1:0] rr_ptr_r;

  logic             grant_req_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic             grant_s;
  logic [NCH-1:0]   grant_oh_s;
  logic [7:0]       grant_data_s;

  logic             hs_s;
  logic             last_hs_s;
  logic             out_free_s;
  logic             would_load_s;
  logic             load_s;
  logic [7:0]       load_data_s;

  logic             pack_shift_s;
  logic             pack_clr_s;
  logic [7:0]       pack_byte_s;
  logic             pack_done_s;

  logic [7:0]       dout_r;
  logic             dout_valid_r;
  logic             burst_act_r;

  assign DOUT       = dout_r;
  assign DOUT_VALID = dout_valid_r;
  assign BURST_ACT  = burst_act_r;

  // Round-robin search over full hold entries starting at the pointer.
  always_comb begin
    int unsigned idx;
    logic        hit;
    grant_req_s = 1'b0;
    grant_idx_s = '0;
    idx         = 0;
    hit         = 1'b0;
    // Walk from farthest to nearest so the nearest full entry wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      idx         = (int'(rr_ptr_r) + k) % NCH;
      hit         = hold_full_r[idx];
      grant_req_s = grant_req_s | hit;
      grant_idx_s = hit ? IDX_W'(idx) : grant_idx_s;
    end
  end

  // Grant qualification, packer control and output-register load selection.
  always_comb begin
    hs_s         = dout_valid_r & DOUT_READY;
    out_free_s   = ~dout_valid_r | DOUT_READY;
    last_hs_s    = hs_s & (burst_cnt_r == CNT_W'(BURST_LEN - 1));
    // Packer shifts that do not finish a byte never touch the output reg.
    would_load_s = (MODE == MODE_RAW) | pack_done_s;
    // The handshake ending a burst takes no new load, so the burst stays
    // exactly BURST_LEN bytes; the waiting sample is discarded by the drain.
    grant_s      = grant_req_s & (state_r == ST_SEND) &
                   (~would_load_s | (out_free_s & ~last_hs_s));
    grant_oh_s   = grant_s ? (NCH'(1) << grant_idx_s) : '0;
    grant_data_s = hold_data_r[grant_idx_s];
    pack_shift_s = grant_s & (MODE == MODE_PACK);
    pack_clr_s   = (state_r == ST_DRAIN);
    load_s       = grant_s & would_load_s;
    load_data_s  = (MODE == MODE_RAW) ? grant_data_s : pack_byte_s;
  end

  trng_bit_packer u_packer (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (pack_clr_s),
    .SHIFT     (pack_shift_s),
    .BIT_IN    (grant_data_s[0]),
    .BYTE_OUT  (pack_byte_s),
    .BYTE_DONE (pack_done_s)
  );

  // Hold entries: strobes write (new sample wins over a same-cycle grant), grants empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_full_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        hold_data_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state_r == ST_DRAIN) begin
          hold_full_r[i] <= 1'b0;
        end else if (SMP_EN[i]) begin
          hold_data_r[i] <= SMP_DATA[8*i +: 8];
          hold_full_r[i] <= 1'b1;
        end else if (grant_oh_s[i]) begin
          hold_full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer moves to the channel after the one just granted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      rr_ptr_r <= (grant_idx_s == IDX_W'(NCH - 1)) ? '0 : grant_idx_s + IDX_W'(1);
    end
  end

  // Output register: load sets valid, handshake clears it unless reloaded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_r       <= 8'd0;
      dout_valid_r <= 1'b0;
    end else if (load_s) begin
      dout_r       <= load_data_s;
      dout_valid_r <= 1'b1;
    end else if (hs_s) begin
      dout_valid_r <= 1'b0;
    end
  end

  // Burst FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SEND: begin
        if (last_hs_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DRAIN: begin
        if (UART_EMPTY && !dout_valid_r) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_SEND;
      end
    endcase
  end

  // Burst FSM state register and the LED flag that mirrors it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_SEND;
      burst_act_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      burst_act_r <= (state_nxt_s == ST_SEND);
    end
  end

  // Burst byte counter: one per handshake, cleared when a new burst starts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      burst_cnt_r <= '0;
    end else if ((state_r == ST_DRAIN) && (state_nxt_s == ST_SEND)) begin
      burst_cnt_r <= '0;
    end else if (hs_s) begin
      burst_cnt_r <= burst_cnt_r + CNT_W'(1);
    end
  end

`ifdef TRNG_DROP_CNT_EN
  logic [NCH-1:0]    drop_vec_s;
  logic [DROP_W-1:0] drop_cnt_r;

  // A drop is a strobe into a full entry that is not granted this cycle.
  always_comb begin
    drop_vec_s = '0;
    if (state_r == ST_SEND) begin
      drop_vec_s = SMP_EN & hold_full_r & ~grant_oh_s;
    end else begin
      drop_vec_s = '0;
    end
  end

  // Saturating count of all channel drops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_r <= '0;
    end else begin
      drop_cnt_r <= sat_add(drop_cnt_r, popcount8(8'(drop_vec_s)));
    end
  end

  assign DROP_CNT = drop_cnt_r;
`endif

endmodule

// File: tb/tb_trng_burst_ctrl.sv
// Self-checking bench for trng_burst_ctrl (NCH=2, BURST_LEN=4).
// Expected byte streams are built from the sample values and bit sequences
// the bench itself generates; a monitor records every handshake.
module tb_trng_burst_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        MODE;
  logic [15:0] SMP_DATA;
  logic [1:0]  SMP_EN;
  logic [7:0]  DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  logic        UART_EMPTY;
  logic        BURST_ACT;
`ifdef TRNG_DROP_CNT_EN
  logic [15:0] DROP_CNT;
`endif

  int checks;
  int failures;
  int hs_cnt;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  trng_burst_ctrl #(.NCH(2), .BURST_LEN(4), .CNT_W(12)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .MODE       (MODE),
    .SMP_DATA   (SMP_DATA),
    .SMP_EN     (SMP_EN),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .UART_EMPTY (UART_EMPTY),
    .BURST_ACT  (BURST_ACT)
`ifdef TRNG_DROP_CNT_EN
    , .DROP_CNT (DROP_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every accepted byte.
  always @(posedge CLK) begin
    if (RST_N === 1'b1 && DOUT_VALID === 1'b1 && DOUT_READY === 1'b1) begin
      got_q.push_back(DOUT);
      hs_cnt = hs_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST_N  = 1'b0;
    SMP_EN = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    got_q.delete();
    exp_q.delete();
    hs_cnt = 0;
    RST_N  = 1'b1;
  endtask

  // One-cycle strobe on the given channel; returns at the next falling edge.
  task automatic strobe(input int ch, input logic [7:0] d);
    SMP_EN       = 2'b00;
    SMP_EN[ch]   = 1'b1;
    SMP_DATA     = 16'd0;
    SMP_DATA[8*ch +: 8] = d;
    @(negedge CLK);
    SMP_EN = 2'b00;
  endtask

  task automatic wait_hs(input string tag, input int n);
    int c;
    c = 0;
    while (hs_cnt < n && c < 200) begin
      @(negedge CLK);
      c++;
    end
    chk(tag, 32'(hs_cnt >= n), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  function automatic logic [7:0] pack_bits(input logic b [8]);
    logic [7:0] v;
    v = 8'd0;
    for (int i = 0; i < 8; i++) begin
      v = v + (8'(b[i]) << (7 - i));
    end
    return v;
  endfunction

  initial begin
    logic [7:0] d;
    logic [7:0] first0;
    logic [7:0] last0;
    logic [7:0] last1;
    logic       bits [8];
    logic       rb [43];
    logic [7:0] b2_pat;
    int         ch;
    int         drop_before;

    checks = 0; failures = 0; hs_cnt = 0;
    MODE = 1'b0; SMP_EN = 2'b00; SMP_DATA = 16'd0;
    DOUT_READY = 1'b1; UART_EMPTY = 1'b1; RST_N = 1'b0;
    drop_before = 0;

    // Reset state
    @(negedge CLK);
    chk("rst_dout", 32'(DOUT), 32'h00);
    chk("rst_valid", 32'(DOUT_VALID), 32'd0);
    chk("rst_burst_act", 32'(BURST_ACT), 32'd1);
`ifdef TRNG_DROP_CNT_EN
    chk("rst_drop", 32'(DROP_CNT), 32'd0);
`endif
    RST_N = 1'b1;
    @(negedge CLK);

    // 1: raw mode, A5 then 3C, latency t+2
    SMP_EN = 2'b01; SMP_DATA = 16'h00A5;
    @(negedge CLK);
    chk("t1_valid_t1", 32'(DOUT_VALID), 32'd0);
    SMP_EN = 2'b10; SMP_DATA = 16'h3C00;
    @(negedge CLK);
    SMP_EN = 2'b00;
    chk("t1_valid_t2", 32'(DOUT_VALID), 32'd1);
    chk("t1_dout_a5", 32'(DOUT), 32'hA5);
    @(negedge CLK);
    chk("t1_valid_b2", 32'(DOUT_VALID), 32'd1);
    chk("t1_dout_3c", 32'(DOUT), 32'h3C);
    @(negedge CLK);
    chk("t1_hs_cnt", 32'(hs_cnt), 32'd2);

    // Random raw-mode rounds: stream equals strobe order
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int j = 0; j < 3; j++) begin
        ch = int'($urandom_range(0, 1));
        d  = 8'($urandom);
        exp_q.push_back(d);
        strobe(ch, d);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      wait_hs($sformatf("rr%0d_wait", r), 3);
      @(negedge CLK);
      cmp_stream($sformatf("rr%0d", r));
    end

    // 2: pack mode, fixed pattern then two random bytes
    RST_N = 1'b0; MODE = 1'b1;
    do_reset();
    b2_pat = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      d[0] = b2_pat[7 - i];
      strobe(0, d);
      chk($sformatf("t2_novalid_%0d", i), 32'(DOUT_VALID), 32'd0);
    end
    @(negedge CLK);
    chk("t2_valid", 32'(DOUT_VALID), 32'd1);
    chk("t2_dout_b2", 32'(DOUT), 32'hB2);
    exp_q.push_back(8'hB2);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        bits[i] = 1'($urandom);
        d = 8'($urandom);
        d[0] = bits[i];
        strobe(i % 2, d);
      end
      exp_q.push_back(pack_bits(bits));
    end
    wait_hs("t2_wait", 3);
    @(negedge CLK);
    cmp_stream("t2");

    // 3: burst limit and resume
    RST_N = 1'b0; MODE = 1'b0;
    do_reset();
    UART_EMPTY = 1'b0;
    for (int j = 0; j < 6; j++) begin
      d = 8'($urandom);
      if (j < 4) exp_q.push_back(d);
      strobe(j % 2, d);
    end
    repeat (10) @(negedge CLK);
    chk("t3_hs4", 32'(hs_cnt), 32'd4);
    chk("t3_act_low", 32'(BURST_ACT), 32'd0);
    chk("t3_valid_low", 32'(DOUT_VALID), 32'd0);
    cmp_stream("t3a");
    UART_EMPTY = 1'b1;
    @(negedge CLK);
    chk("t3_resume", 32'(BURST_ACT), 32'd1);
    UART_EMPTY = 1'b0;
    got_q.delete(); exp_q.delete(); hs_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      d = 8'($urandom);
      if (j < 4) exp_q.push_back(d);
      strobe(j % 2, d);
    end
    repeat (10) @(negedge CLK);
    chk("t3_hs4_again", 32'(hs_cnt), 32'd4);
    chk("t3_act_low2", 32'(BURST_ACT), 32'd0);
    cmp_stream("t3b");
    UART_EMPTY = 1'b1;

    // 4: READY low, both channels strobing every cycle
    RST_N = 1'b0; MODE = 1'b0;
    do_reset();
    DOUT_READY = 1'b0;
    first0 = 8'd0; last0 = 8'd0; last1 = 8'd0;
    for (int c = 0; c < 6; c++) begin
      last0 = 8'($urandom);
      last1 = 8'($urandom);
      if (c == 0) first0 = last0;
      SMP_EN = 2'b11;
      SMP_DATA = {last1, last0};
      @(negedge CLK);
      if (c >= 1) begin
        chk($sformatf("t4_valid_%0d", c), 32'(DOUT_VALID), 32'd1);
        chk($sformatf("t4_dout_%0d", c), 32'(DOUT), 32'(first0));
      end
`ifdef TRNG_DROP_CNT_EN
      chk($sformatf("t4_drop_%0d", c), 32'(DROP_CNT), (c == 0) ? 32'd0 : 32'(2 * c - 1));
`endif
    end
    SMP_EN = 2'b00;
    DOUT_READY = 1'b1;
    exp_q.push_back(first0);
    exp_q.push_back(last1);
    exp_q.push_back(last0);
    wait_hs("t4_wait", 3);
    @(negedge CLK);
    cmp_stream("t4");

    // 5: drain with partial packer byte and ignored strobes
    RST_N = 1'b0; MODE = 1'b1; UART_EMPTY = 1'b0;
    do_reset();
    for (int i = 0; i < 43; i++) rb[i] = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) bits[i] = rb[8*k + i];
      exp_q.push_back(pack_bits(bits));
    end
    for (int i = 0; i < 8; i++) bits[i] = rb[35 + i];
    exp_q.push_back(pack_bits(bits));
    for (int i = 0; i < 24; i++) strobe(0, {7'($urandom), rb[i]});
    wait_hs("t5_wait3", 3);
    DOUT_READY = 1'b0;
    for (int i = 24; i < 35; i++) strobe(0, {7'($urandom), rb[i]});
    repeat (3) @(negedge CLK);
    chk("t5_hs3", 32'(hs_cnt), 32'd3);
    chk("t5_valid_held", 32'(DOUT_VALID), 32'd1);
`ifdef TRNG_DROP_CNT_EN
    drop_before = int'(DROP_CNT);
    chk("t5_drop_pre", 32'(DROP_CNT), 32'd0);
`endif
    DOUT_READY = 1'b1;
    @(negedge CLK);
    chk("t5_drain", 32'(BURST_ACT), 32'd0);
    for (int c = 0; c < 4; c++) begin
      SMP_EN = 2'b11;
      SMP_DATA = 16'($urandom);
      @(negedge CLK);
    end
    SMP_EN = 2'b00;
    chk("t5_still_drain", 32'(BURST_ACT), 32'd0);
`ifdef TRNG_DROP_CNT_EN
    chk("t5_drop_same", 32'(DROP_CNT), 32'(drop_before));
`endif
    UART_EMPTY = 1'b1;
    @(negedge CLK);
    chk("t5_resume", 32'(BURST_ACT), 32'd1);
    for (int i = 35; i < 43; i++) strobe(0, {7'($urandom), rb[i]});
    wait_hs("t5_wait5", 5);
    @(negedge CLK);
    cmp_stream("t5");

    // 6: asynchronous reset mid-burst
    RST_N = 1'b0; MODE = 1'b0;
    do_reset();
    DOUT_READY = 1'b0;
    strobe(0, 8'($urandom));
    @(negedge CLK);
    chk("t6_valid_pre", 32'(DOUT_VALID), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(DOUT_VALID), 32'd0);
    chk("t6_act_rst", 32'(BURST_ACT), 32'd1);
    chk("t6_dout_rst", 32'(DOUT), 32'd0);
    @(negedge CLK);
    got_q.delete(); exp_q.delete(); hs_cnt = 0;
    RST_N = 1'b1;
    DOUT_READY = 1'b1;
    d = 8'($urandom);
    exp_q.push_back(d);
    strobe(1, d);
    wait_hs("t6_wait", 1);
    @(negedge CLK);
    cmp_stream("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
